// File: rtl/fp_rf_pkg.sv
// Shared types and constants for the floating-point register file:
// FSM state encoding, default geometry, FCSR flag bit positions and
// rounding-mode encodings, plus the flag-accrual helper.
package fp_rf_pkg;

    localparam int FP_NREGS = 32;
    localparam int FP_DW    = 32;
    localparam int FP_AW    = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fp_state_e;

    // Accrued exception flag bit positions within fflags {NV,DZ,OF,UF,NX}
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Rounding-mode encodings held in frm
    localparam logic [2:0] FRM_RNE = 3'b000;
    localparam logic [2:0] FRM_RTZ = 3'b001;
    localparam logic [2:0] FRM_RDN = 3'b010;
    localparam logic [2:0] FRM_RUP = 3'b011;
    localparam logic [2:0] FRM_RMM = 3'b100;

    // Sticky OR of new FPU flags onto a base value, only when a result lands
    function automatic logic [4:0] accrue_flags(input logic [4:0] base,
                                                input logic [4:0] new_flags,
                                                input logic       en);
        return base | (en ? new_flags : 5'b0);
    endfunction

endpackage

// File: rtl/fp_register_file_if.sv
// Bundle of all issue, load/store, FPU-result and CSR signals between the
// pipeline/FPU side (master) and the FP register file (slave).
interface fp_register_file_if
    import fp_rf_pkg::*;
#(
    parameter int DW = FP_DW
) ();
    logic [FP_AW-1:0] f_rs1;
    logic [FP_AW-1:0] f_rs2;
    logic [FP_AW-1:0] f_rd;
    logic             issue;
    logic             f_LW;
    logic [DW-1:0]    load_data;
    logic             f_SW;
    logic [DW-1:0]    store_data;
    logic [DW-1:0]    FPU_out;
    logic [4:0]       flags;
    logic             f_ready;
    logic             frm_we;
    logic [2:0]       frm_wdata;
    logic             fflags_we;
    logic [4:0]       fflags_wdata;
    logic [DW-1:0]    f_rs1_data;
    logic [DW-1:0]    f_rs2_data;
    logic [2:0]       frm;
    logic [4:0]       f_flags;
    logic             busy;
    logic             stall;

    modport slave (
        input  f_rs1, f_rs2, f_rd, issue, f_LW, load_data, f_SW,
               FPU_out, flags, f_ready, frm_we, frm_wdata, fflags_we, fflags_wdata,
        output store_data, f_rs1_data, f_rs2_data, frm, f_flags, busy, stall
    );

    modport master (
        output f_rs1, f_rs2, f_rd, issue, f_LW, load_data, f_SW,
               FPU_out, flags, f_ready, frm_we, frm_wdata, fflags_we, fflags_wdata,
        input  store_data, f_rs1_data, f_rs2_data, frm, f_flags, busy, stall
    );

endinterface

// File: rtl/fp_rf_hazard_unit.sv
// Single-entry pending-write scoreboard for the one in-flight FPU op.
// Tracks IDLE/BUSY and the pending destination, and raises stall on any
// issue, WAW load or RAW store against the pending register.
// FP_REG_BYPASS_EN: the completion cycle resolves the hazard (stall forced
// low, operand forwarding enabled, a new issue is accepted back-to-back).
module fp_rf_hazard_unit
    import fp_rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_i,
    input  logic             f_ready_i,
    input  logic             f_lw_i,
    input  logic             f_sw_i,
    input  logic [FP_AW-1:0] f_rd_i,
    input  logic [FP_AW-1:0] f_rs2_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             complete_o,
    output logic             byp_en_o,
    output logic [FP_AW-1:0] pend_rd_o
);

    fp_state_e        state_q, state_d;
    logic [FP_AW-1:0] pend_rd_q, pend_rd_d;
    logic             hazard;

    // State and pending-destination registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_rd_q <= pend_rd_d;
        end
    end

    // Hazard detection, stall and next-state selection
    always_comb begin
        state_d    = state_q;
        pend_rd_d  = pend_rd_q;
        complete_o = (state_q == BUSY) && f_ready_i;
        hazard     = (state_q == BUSY) &&
                     (issue_i ||
                      (f_lw_i && (f_rd_i  == pend_rd_q)) ||
                      (f_sw_i && (f_rs2_i == pend_rd_q)));
`ifdef FP_REG_BYPASS_EN
        stall_o    = hazard && !complete_o;
        byp_en_o   = complete_o;
`else
        stall_o    = hazard;
        byp_en_o   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (issue_i && !stall_o) begin
                    state_d   = BUSY;
                    pend_rd_d = f_rd_i;
                end
            end
            BUSY: begin
                if (f_ready_i) begin
                    if (issue_i && !stall_o) begin
                        pend_rd_d = f_rd_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o    = (state_q == BUSY);
    assign pend_rd_o = pend_rd_q;

endmodule

// File: rtl/fp_register_file.sv
// Floating-point register file with FCSR (frm, accrued fflags).
// Two write ports: FPU completion to the pending register and FLW load.
// Reads are combinational; f0 is an ordinary register.
// FP_REG_BYPASS_EN: forwards FPU_out to reads of the completing register.
module fp_register_file
    import fp_rf_pkg::*;
#(
    parameter int NREGS = FP_NREGS,
    parameter int DW    = FP_DW
) (
    input logic                clk,
    input logic                n_rst,
    fp_register_file_if.slave  rf
);

    logic [DW-1:0]    regs_q [NREGS];
    logic [2:0]       frm_q;
    logic [4:0]       fflags_q;
    logic             busy, stall, complete, byp_en;
    logic [FP_AW-1:0] pend_rd;
    logic [DW-1:0]    rs1_data, rs2_data;

    fp_rf_hazard_unit u_hazard (
        .clk        (clk),
        .rst        (n_rst),
        .issue_i    (rf.issue),
        .f_ready_i  (rf.f_ready),
        .f_lw_i     (rf.f_LW),
        .f_sw_i     (rf.f_SW),
        .f_rd_i     (rf.f_rd),
        .f_rs2_i    (rf.f_rs2),
        .busy_o     (busy),
        .stall_o    (stall),
        .complete_o (complete),
        .byp_en_o   (byp_en),
        .pend_rd_o  (pend_rd)
    );

    // Register array: FPU completion and load commit; the load is the younger
    // instruction, so it wins if both ever target the same register
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (complete) begin
                regs_q[pend_rd] <= rf.FPU_out;
            end
            if (rf.f_LW && !stall) begin
                regs_q[rf.f_rd] <= rf.load_data;
            end
        end
    end

    // FCSR: CSR writes are independent of the FSM; a same-cycle FPU result
    // still ORs its flags on top of a software fflags write
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            frm_q    <= FRM_RNE;
            fflags_q <= 5'b0;
        end else begin
            if (rf.frm_we) begin
                frm_q <= rf.frm_wdata;
            end
            if (rf.fflags_we) begin
                fflags_q <= accrue_flags(rf.fflags_wdata, rf.flags, complete);
            end else begin
                fflags_q <= accrue_flags(fflags_q, rf.flags, complete);
            end
        end
    end

    // Operand reads with optional forwarding of the completing result
    always_comb begin
        rs1_data = regs_q[rf.f_rs1];
        rs2_data = regs_q[rf.f_rs2];
        if (byp_en && (rf.f_rs1 == pend_rd)) begin
            rs1_data = rf.FPU_out;
        end
        if (byp_en && (rf.f_rs2 == pend_rd)) begin
            rs2_data = rf.FPU_out;
        end
    end

    assign rf.f_rs1_data = rs1_data;
    assign rf.f_rs2_data = rs2_data;
    assign rf.store_data = rs2_data;
    assign rf.frm        = frm_q;
    assign rf.f_flags    = fflags_q;
    assign rf.busy       = busy;
    assign rf.stall      = stall;

endmodule
